// File: rtl/seq_div.sv
// seq_div: multi-cycle restoring divider producing one quotient bit per clock.
// A start in IDLE or DONE latches the operands. W shift/subtract steps run in
// BUSY. A final FINISH cycle then loads quot/rem/dz and raises the one-cycle
// done pulse. The results hold until the next done or reset.
// Optional feature: define SEQDIV_SIGNED_EN for two's complement operands
// (truncating division, remainder takes the dividend's sign).
module seq_div #(
    parameter int DATAWIDTH = 8
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 start,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [DATAWIDTH-1:0] quot,
    output logic [DATAWIDTH-1:0] rem,
    output logic                 dz
);

    localparam int W  = DATAWIDTH;
    localparam int CW = $clog2(W + 1);

    // FINISH is the result-loading cycle between the last step and the done pulse
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        FINISH = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t         state;
    logic [W-1:0]   dividend;
    logic [W-1:0]   divisor;
    logic [W-1:0]   part_rem;
    logic [CW-1:0]  count;
    logic           div_zero;

    logic [W:0]     shifted;
    logic           fits;
    logic [W-1:0]   diff;
    logic [W-1:0]   a_mag;
    logic [W-1:0]   b_mag;
    logic [W-1:0]   q_final;
    logic [W-1:0]   r_final;

`ifdef SEQDIV_SIGNED_EN
    logic           neg_quot;
    logic           neg_rem;

    // Operand magnitudes and sign fix-up of the finished magnitudes
    always_comb begin
        a_mag   = a[W-1] ? (-a) : a;
        b_mag   = b[W-1] ? (-b) : b;
        q_final = neg_quot ? (-dividend) : dividend;
        r_final = neg_rem ? (-part_rem) : part_rem;
    end
`else
    // Unsigned operands pass straight through
    always_comb begin
        a_mag   = a;
        b_mag   = b;
        q_final = dividend;
        r_final = part_rem;
    end
`endif

    // One restoring step: bring in the next dividend bit and trial-subtract.
    // When the trial fits, the true difference is below the divisor, so the
    // low W bits of the subtraction are exact.
    always_comb begin
        shifted = {part_rem, dividend[W-1]};
        fits    = (shifted >= {1'b0, divisor});
        diff    = shifted[W-1:0] - divisor;
    end

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            quot     <= '0;
            rem      <= '0;
            dz       <= 1'b0;
            dividend <= '0;
            divisor  <= '0;
            part_rem <= '0;
            count    <= '0;
            div_zero <= 1'b0;
`ifdef SEQDIV_SIGNED_EN
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        divisor  <= b_mag;
                        part_rem <= '0;
                        count    <= CW'(W);
                        div_zero <= (b == '0);
`ifdef SEQDIV_SIGNED_EN
                        neg_quot <= a[W-1] ^ b[W-1];
                        neg_rem  <= a[W-1];
`endif
                        if (b == '0) begin
                            // Raw dividend is kept so it can be returned as rem
                            dividend <= a;
                            busy     <= 1'b0;
                            state    <= FINISH;
                        end else begin
                            dividend <= a_mag;
                            busy     <= 1'b1;
                            state    <= BUSY;
                        end
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    if (fits) begin
                        part_rem <= diff;
                        dividend <= {dividend[W-2:0], 1'b1};
                    end else begin
                        part_rem <= shifted[W-1:0];
                        dividend <= {dividend[W-2:0], 1'b0};
                    end
                    count <= count - 1'b1;
                    if (count == CW'(1)) begin
                        busy  <= 1'b0;
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    if (div_zero) begin
                        quot <= '1;
                        rem  <= dividend;
                    end else begin
                        quot <= q_final;
                        rem  <= r_final;
                    end
                    dz    <= div_zero;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= DONE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: self-checking bench for seq_div.
// It applies a table of hand-derived vectors, a set of multi-cycle corner
// sequences and randomized operations. All of these are checked against an
// arithmetic reference model.
module tb_seq_div;

    localparam int W = 8;

    logic         Clk = 1'b0;
    logic         Rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] quot;
    logic [W-1:0] rem;
    logic         dz;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] last_q;
    logic [W-1:0] last_r;
    logic         last_dz;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } vec_t;

    vec_t vecs[$];

    seq_div #(.DATAWIDTH(W)) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .quot  (quot),
        .rem   (rem),
        .dz    (dz)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] simulation time limit");
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    // Reference: plain integer division straight from the operand rules
    task automatic model_div(input logic [W-1:0] x, input logic [W-1:0] y,
                             output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
`ifdef SEQDIV_SIGNED_EN
        int sx;
        int sy;
        sx = $signed(x);
        sy = $signed(y);
        if (y == '0) begin
            q = '1;
            r = x;
            z = 1'b1;
        end else begin
            q = W'(sx / sy);
            r = W'(sx % sy);
            z = 1'b0;
        end
`else
        if (y == '0) begin
            q = '1;
            r = x;
            z = 1'b1;
        end else begin
            q = x / y;
            r = x % y;
            z = 1'b0;
        end
`endif
    endtask

    // Present a start for exactly one edge (E0), then scramble the operands
    task automatic apply_stimulus(input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1;
        a     = x;
        b     = y;
        tick();
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
    endtask

    // Wait (bounded) for done after E0 and check latency, busy span, hold and results.
    // inject_at >= 0 drives an extra start (9/9) during that cycle of the operation.
    task automatic wait_result(input string name, input logic [W-1:0] eq, input logic [W-1:0] er,
                               input logic ez, input int inject_at);
        int   edges;
        int   busy_cycles;
        int   exp_lat;
        int   exp_busy;
        logic held;
        logic seen;
        exp_lat     = ez ? 1 : W + 1;
        exp_busy    = ez ? 0 : W;
        edges       = 0;
        busy_cycles = 0;
        held        = 1'b1;
        seen        = 1'b0;
        while (!seen && edges < 4 * W + 8) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) busy_cycles++;
                if (quot !== last_q || rem !== last_r || dz !== last_dz) held = 1'b0;
                if (edges == inject_at) begin
                    start = 1'b1;
                    a     = 8'd9;
                    b     = 8'd9;
                end else begin
                    start = 1'b0;
                end
                tick();
                edges++;
            end
        end
        start = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout actual=no_done required=done_within_%0d_edges", name, exp_lat);
        end else begin
            check_output({name, "_latency"}, edges, exp_lat);
            check_output({name, "_busy_cycles"}, busy_cycles, exp_busy);
            check_output({name, "_held"}, held, 1'b1);
            check_output({name, "_quot"}, quot, eq);
            check_output({name, "_rem"}, rem, er);
            check_output({name, "_dz"}, dz, ez);
            check_output({name, "_busy_at_done"}, busy, 1'b0);
        end
        last_q  = eq;
        last_r  = er;
        last_dz = ez;
    endtask

    initial begin
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         ez;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         any_done;

        Rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;

`ifdef SEQDIV_SIGNED_EN
        vecs.push_back('{8'hF9, 8'd2,  8'hFD, 8'hFF, 1'b0});
        vecs.push_back('{8'h80, 8'hFF, 8'h80, 8'd0,  1'b0});
        vecs.push_back('{8'd20, 8'd0,  8'hFF, 8'd20, 1'b1});
        vecs.push_back('{8'd100, 8'd7, 8'd14, 8'd2,  1'b0});
        vecs.push_back('{8'd7,  8'hFE, 8'hFD, 8'd1,  1'b0});
        vecs.push_back('{8'd9,  8'd9,  8'd1,  8'd0,  1'b0});
`else
        vecs.push_back('{8'd100, 8'd7,  8'd14,  8'd2,   1'b0});
        vecs.push_back('{8'd20,  8'd0,  8'd255, 8'd20,  1'b1});
        vecs.push_back('{8'd200, 8'd3,  8'd66,  8'd2,   1'b0});
        vecs.push_back('{8'd9,   8'd9,  8'd1,   8'd0,   1'b0});
        vecs.push_back('{8'd5,   8'd9,  8'd0,   8'd5,   1'b0});
        vecs.push_back('{8'd0,   8'd1,  8'd0,   8'd0,   1'b0});
        vecs.push_back('{8'd255, 8'd1,  8'd255, 8'd0,   1'b0});
        vecs.push_back('{8'd255, 8'd255, 8'd1,  8'd0,   1'b0});
        vecs.push_back('{8'd254, 8'd16, 8'd15,  8'd14,  1'b0});
        vecs.push_back('{8'd1,   8'd0,  8'd255, 8'd1,   1'b1});
        vecs.push_back('{8'd0,   8'd0,  8'd255, 8'd0,   1'b1});
        vecs.push_back('{8'd128, 8'd128, 8'd1,  8'd0,   1'b0});
`endif

        // Reset held for two edges
        tick();
        tick();
        Rst = 1'b0;
        check_output("reset_quot", quot, 0);
        check_output("reset_rem", rem, 0);
        check_output("reset_dz", dz, 0);
        check_output("reset_done", done, 0);
        check_output("reset_busy", busy, 0);
        last_q  = '0;
        last_r  = '0;
        last_dz = 1'b0;

        // Table-driven vectors, each followed by a done-pulse width check
        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i].a, vecs[i].b);
            wait_result($sformatf("vec%0d", i), vecs[i].q, vecs[i].r, vecs[i].dz, -1);
            tick();
            check_output($sformatf("vec%0d_done_pulse", i), done, 0);
        end

        // Start mid-operation is ignored, then a back-to-back start on the done cycle
        model_div(8'd200, 8'd3, eq, er, ez);
        apply_stimulus(8'd200, 8'd3);
        wait_result("ignore_mid_busy", eq, er, ez, 2);
        model_div(8'd9, 8'd9, eq, er, ez);
        apply_stimulus(8'd9, 8'd9);
        wait_result("back_to_back", eq, er, ez, -1);
        tick();

        // Reset aborts an operation in flight at edge E4
        apply_stimulus(8'd50, 8'd5);
        tick();
        tick();
        tick();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        check_output("abort_quot", quot, 0);
        check_output("abort_rem", rem, 0);
        check_output("abort_dz", dz, 0);
        check_output("abort_busy", busy, 0);
        any_done = 1'b0;
        for (int i = 0; i < 2 * W; i++) begin
            if (done) any_done = 1'b1;
            tick();
        end
        check_output("abort_no_done", any_done, 0);
        last_q  = '0;
        last_r  = '0;
        last_dz = 1'b0;
        model_div(8'd50, 8'd5, eq, er, ez);
        apply_stimulus(8'd50, 8'd5);
        wait_result("after_abort", eq, er, ez, -1);

        // Randomized operations with a mix of idle gaps and back-to-back starts
        for (int i = 0; i < 40; i++) begin
            x = W'($urandom);
            case ($urandom_range(0, 4))
                0:       y = '0;
                1:       y = W'($urandom_range(1, 15));
                2:       y = x;
                default: y = W'($urandom);
            endcase
            model_div(x, y, eq, er, ez);
            if ($urandom_range(0, 1) == 0) begin
                for (int k = 0; k < int'($urandom_range(1, 3)); k++) tick();
            end
            apply_stimulus(x, y);
            wait_result($sformatf("rand%0d", i), eq, er, ez, -1);
        end
        tick();
        check_output("final_done_low", done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
